write_queue_param: RTL and testbench

- Parametrised write-back queue between the dcache and the memory arbiter.
- Buffers dirty evictions from the dcache and drains them to memory one word at a time over a dwait handshake.
- Beyond the earlier queue:
  - configurable depth and widths;
  - same-address write coalescing;
  - read-miss forwarding from queued data;
  - a high-water and flush policy that decides between miss-read priority and forced drain.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/wq_match.sv | 34 +++
 rtl/write_queue_param.sv | 152 +++++++++++++++
 tb/tb_write_queue_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the write-back queue state and entry layout.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        WQ_IDLE  = 1'b0,
        WQ_DRAIN = 1'b1
    } wq_state_t;

    typedef struct packed {
        logic  valid;
        word_t addr;
        word_t data;
    } wq_entry_t;

endpackage

// File: rtl/wq_match.sv
// CAM compare of one key against all queue entries; the youngest matching entry wins.
module wq_match #(
    parameter int N  = 4,
    parameter int AW = 32
) (
    input  logic [AW-1:0]         key,
    input  logic [N-1:0][AW-1:0]  addrs,
    input  logic [N-1:0]          valid,
    input  logic [$clog2(N)-1:0]  head,
    output logic                  hit,
    output logic [$clog2(N)-1:0]  idx
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] pos_s;

    // Walk oldest to youngest from head so the last match seen is the youngest.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        pos_s = '0;
        for (int k = 0; k < N; k++) begin
            pos_s = head + PW'(k);
            if (valid[pos_s] && (addrs[pos_s] == key)) begin
                hit = 1'b1;
                idx = pos_s;
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/write_queue_param.sv
// Parametrised dcache write-back queue with coalescing, miss forwarding and a drain policy.
module write_queue_param
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int HIWAT  = DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ddirtyWEN,
    input  logic [ADDR_W-1:0] ddirtyaddr,
    input  logic [DATA_W-1:0] ddirtydata,
    output logic              full,
    output logic              wempty,
    input  logic              dmissREN,
    input  logic [ADDR_W-1:0] dmissaddr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    input  logic              flush,
    output logic              dqueueWEN,
    output logic [ADDR_W-1:0] wdaddr,
    output logic [DATA_W-1:0] dstore,
    input  logic              dwait
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]             vld_r;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_r;
    logic [DEPTH-1:0][DATA_W-1:0] data_r;
    logic [PW-1:0]                head_r, tail_r;
    logic [CW-1:0]                count_r;
    wq_state_t                    state_r;

    logic [DEPTH-1:0]  coal_mask_s;
    logic              coal_hit_s, fwd_match_s;
    logic [PW-1:0]     coal_idx_s, fwd_idx_s;
    logic              accept_s, coal_s, app_s, pop_s, cond_s, go_s, load_s;
    logic [CW-1:0]     cnt_pop_s, count_nx_s;
    logic [PW-1:0]     nh_s;
    wq_state_t         state_nx_s;
    logic [ADDR_W-1:0] nxt_addr_s;
    logic [DATA_W-1:0] nxt_data_s;

    assign full   = (count_r == CW'(DEPTH));
    assign wempty = (count_r == '0) && (state_r == WQ_IDLE);

    // The in-flight head must never be coalesced into.
    always_comb begin
        coal_mask_s = vld_r;
        if (state_r == WQ_DRAIN) begin
            coal_mask_s[head_r] = 1'b0;
        end else begin
            coal_mask_s = vld_r;
        end
    end

    wq_match #(.N(DEPTH), .AW(ADDR_W)) u_coal_match (
        .key   (ddirtyaddr),
        .addrs (addr_r),
        .valid (coal_mask_s),
        .head  (head_r),
        .hit   (coal_hit_s),
        .idx   (coal_idx_s)
    );

    wq_match #(.N(DEPTH), .AW(ADDR_W)) u_fwd_match (
        .key   (dmissaddr),
        .addrs (addr_r),
        .valid (vld_r),
        .head  (head_r),
        .hit   (fwd_match_s),
        .idx   (fwd_idx_s)
    );

    assign fwd_hit  = dmissREN & fwd_match_s;
    assign fwd_data = fwd_hit ? data_r[fwd_idx_s] : '0;

    // Next-state, occupancy and next head-word selection.
    always_comb begin
        accept_s   = ddirtyWEN & ~full;
        coal_s     = accept_s & coal_hit_s;
        app_s      = accept_s & ~coal_hit_s;
        pop_s      = (state_r == WQ_DRAIN) & ~dwait;
        cnt_pop_s  = count_r - CW'(pop_s);
        count_nx_s = cnt_pop_s + CW'(app_s);
        cond_s     = ~dmissREN | flush | (count_nx_s >= CW'(HIWAT));
        go_s       = (count_nx_s != '0) & cond_s;
        nh_s       = pop_s ? (head_r + PW'(1)) : head_r;
        if (state_r == WQ_IDLE) begin
            state_nx_s = go_s ? WQ_DRAIN : WQ_IDLE;
        end else if (pop_s) begin
            state_nx_s = go_s ? WQ_DRAIN : WQ_IDLE;
        end else begin
            state_nx_s = WQ_DRAIN;
        end
        load_s = (state_nx_s == WQ_DRAIN) && ((state_r == WQ_IDLE) || pop_s);
        // A word landing on the new head this very edge must be taken from the inputs.
        if ((coal_s && (coal_idx_s == nh_s)) || (app_s && (cnt_pop_s == '0))) begin
            nxt_addr_s = ddirtyaddr;
            nxt_data_s = ddirtydata;
        end else begin
            nxt_addr_s = addr_r[nh_s];
            nxt_data_s = data_r[nh_s];
        end
    end

    // Queue storage, pointers, FSM and registered memory-side outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_r     <= '0;
            addr_r    <= '0;
            data_r    <= '0;
            head_r    <= '0;
            tail_r    <= '0;
            count_r   <= '0;
            state_r   <= WQ_IDLE;
            dqueueWEN <= 1'b0;
            wdaddr    <= '0;
            dstore    <= '0;
        end else begin
            if (pop_s) begin
                vld_r[head_r] <= 1'b0;
                head_r        <= head_r + PW'(1);
            end
            if (app_s) begin
                vld_r[tail_r]  <= 1'b1;
                addr_r[tail_r] <= ddirtyaddr;
                data_r[tail_r] <= ddirtydata;
                tail_r         <= tail_r + PW'(1);
            end
            if (coal_s) begin
                data_r[coal_idx_s] <= ddirtydata;
            end
            count_r <= count_nx_s;
            state_r <= state_nx_s;
            if (load_s) begin
                dqueueWEN <= 1'b1;
                wdaddr    <= nxt_addr_s;
                dstore    <= nxt_data_s;
            end else if (state_nx_s == WQ_IDLE) begin
                dqueueWEN <= 1'b0;
                wdaddr    <= '0;
                dstore    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_write_queue_param.sv
// Self-checking bench for write_queue_param: reference-queue scoreboard plus directed sequences.
module tb_write_queue_param;

    localparam int DEPTH = 4;
    localparam int HIWAT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ddirtyWEN, dmissREN, flush, dwait;
    logic [31:0] ddirtyaddr, ddirtydata, dmissaddr;
    logic        full, wempty, fwd_hit, dqueueWEN;
    logic [31:0] fwd_data, wdaddr, dstore;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic [31:0] maddr;
        logic        hit;
        logic [31:0] data;
    } fvec_t;

    ent_t  sb[$];
    bit    m_drain = 1'b0;
    fvec_t ftab[4];

    write_queue_param dut (
        .CLK        (CLK),
        .RST        (RST),
        .ddirtyWEN  (ddirtyWEN),
        .ddirtyaddr (ddirtyaddr),
        .ddirtydata (ddirtydata),
        .full       (full),
        .wempty     (wempty),
        .dmissREN   (dmissREN),
        .dmissaddr  (dmissaddr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .flush      (flush),
        .dqueueWEN  (dqueueWEN),
        .wdaddr     (wdaddr),
        .dstore     (dstore),
        .dwait      (dwait)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference queue: checks every output before the edge, then applies the edge's effect.
    always @(negedge CLK) begin : monitor
        int          cnt, j, newc;
        bit          acc, done, fh, cond;
        logic [31:0] fd;
        ent_t        e;
        if (RST) begin
            sb.delete();
            m_drain = 1'b0;
        end else begin
            cnt = sb.size();
            chk("full", full, cnt == DEPTH);
            chk("wempty", wempty, (cnt == 0) && !m_drain);
            chk("dqueueWEN", dqueueWEN, m_drain);
            if (m_drain && cnt > 0) begin
                chk("wdaddr", wdaddr, sb[0].a);
                chk("dstore", dstore, sb[0].d);
            end else begin
                chk("wdaddr_idle", wdaddr, 0);
                chk("dstore_idle", dstore, 0);
            end
            fh = 1'b0;
            fd = 32'h0;
            if (dmissREN) begin
                for (int i = 0; i < cnt; i++) begin
                    if (sb[i].a == dmissaddr) begin
                        fh = 1'b1;
                        fd = sb[i].d;
                    end
                end
            end
            chk("fwd_hit", fwd_hit, fh);
            chk("fwd_data", fwd_data, fd);
            done = m_drain && !dwait;
            acc  = ddirtyWEN && (cnt < DEPTH);
            j    = -1;
            if (acc) begin
                for (int i = (m_drain ? 1 : 0); i < cnt; i++) begin
                    if (sb[i].a == ddirtyaddr) j = i;
                end
            end
            if (acc && j >= 0) begin
                e     = sb[j];
                e.d   = ddirtydata;
                sb[j] = e;
            end
            if (done) void'(sb.pop_front());
            if (acc && j < 0) begin
                e.a = ddirtyaddr;
                e.d = ddirtydata;
                sb.push_back(e);
            end
            newc = sb.size();
            cond = !dmissREN || flush || (newc >= HIWAT);
            if (!m_drain || done) m_drain = (newc > 0) && cond;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d);
        ddirtyWEN  = 1'b1;
        ddirtyaddr = a;
        ddirtydata = d;
        cyc(1);
        ddirtyWEN  = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int k;
        k = 0;
        while (!wempty && k < 60) begin
            cyc(1);
            k++;
        end
        chk(nm, wempty, 1);
    endtask

    initial begin
        ftab[0] = '{maddr: 32'h104, hit: 1'b1, data: 32'hBBBB};
        ftab[1] = '{maddr: 32'h108, hit: 1'b0, data: 32'h0};
        ftab[2] = '{maddr: 32'h100, hit: 1'b1, data: 32'hAAAA};
        ftab[3] = '{maddr: 32'h0FC, hit: 1'b0, data: 32'h0};

        RST = 1'b1; ddirtyWEN = 1'b0; ddirtyaddr = 32'h0; ddirtydata = 32'h0;
        dmissREN = 1'b0; dmissaddr = 32'h0; flush = 1'b0; dwait = 1'b1;
        cyc(2);
        RST = 1'b0;
        cyc(1);
        chk("rst_wempty", wempty, 1);
        chk("rst_full", full, 0);
        chk("rst_dqueueWEN", dqueueWEN, 0);

        // Stalled head stays stable, then forwarding lookups against queued words.
        enq(32'h100, 32'hAAAA);
        chk("latency_wen", dqueueWEN, 1);
        enq(32'h104, 32'hBBBB);
        cyc(3);
        chk("hold_addr", wdaddr, 32'h100);
        chk("hold_data", dstore, 32'hAAAA);
        dmissREN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dmissaddr = ftab[i].maddr;
            #1;
            chk("fwd_tab_hit", fwd_hit, ftab[i].hit);
            chk("fwd_tab_data", fwd_data, ftab[i].data);
        end
        cyc(1);
        dmissREN = 1'b0;
        cyc(1);
        dwait = 1'b0;
        cyc(1);
        dwait = 1'b1;
        chk("second_addr", wdaddr, 32'h104);
        chk("second_data", dstore, 32'hBBBB);
        dwait = 1'b0;
        wait_empty("drain1_done");

        // High-water drain under a pending miss, overflow write dropped.
        dwait = 1'b1;
        dmissREN = 1'b1;
        dmissaddr = 32'h500;
        enq(32'h200, 32'h10);
        enq(32'h204, 32'h11);
        enq(32'h208, 32'h12);
        chk("below_hiwat_idle", dqueueWEN, 0);
        enq(32'h20C, 32'h13);
        chk("full_at_4", full, 1);
        chk("hiwat_drain", dqueueWEN, 1);
        enq(32'h210, 32'hDEAD);
        chk("full_after_drop", full, 1);
        dmissREN = 1'b0;
        dwait = 1'b0;
        wait_empty("drain2_done");

        // Coalescing, with appends when the address matches the in-flight head.
        dwait = 1'b1;
        enq(32'h000, 32'h5);
        enq(32'h300, 32'h1);
        enq(32'h300, 32'h2);
        enq(32'h000, 32'h7);
        dwait = 1'b0;
        cyc(1);
        dwait = 1'b1;
        chk("coal_addr", wdaddr, 32'h300);
        chk("coal_data", dstore, 32'h2);
        enq(32'h300, 32'h3);
        dwait = 1'b0;
        wait_empty("drain3_done");

        // Flush overrides a pending miss below high-water.
        dwait = 1'b1;
        dmissREN = 1'b1;
        dmissaddr = 32'h400;
        enq(32'h400, 32'h9);
        cyc(2);
        chk("miss_priority", dqueueWEN, 0);
        flush = 1'b1;
        cyc(1);
        chk("flush_drain", dqueueWEN, 1);
        dwait = 1'b0;
        cyc(1);
        flush = 1'b0;
        dmissREN = 1'b0;
        chk("flush_empty", wempty, 1);

        // Asynchronous reset while draining.
        dwait = 1'b1;
        enq(32'h600, 32'h61);
        enq(32'h604, 32'h62);
        #2 RST = 1'b1;
        #1;
        chk("rstmid_wen", dqueueWEN, 0);
        chk("rstmid_wempty", wempty, 1);
        chk("rstmid_full", full, 0);
        chk("rstmid_addr", wdaddr, 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        cyc(2);

        // Randomised traffic on a small address set to force coalesce, forward and simultaneous pops.
        for (int n = 0; n < 400; n++) begin
            ddirtyWEN  = ($urandom_range(0, 1) == 1);
            ddirtyaddr = 32'($urandom_range(0, 5)) * 32'h4;
            ddirtydata = $urandom;
            dwait      = ($urandom_range(0, 2) == 0);
            dmissREN   = ($urandom_range(0, 1) == 1);
            dmissaddr  = 32'($urandom_range(0, 5)) * 32'h4;
            flush      = ($urandom_range(0, 7) == 0);
            cyc(1);
        end
        ddirtyWEN = 1'b0;
        dmissREN  = 1'b0;
        flush     = 1'b0;
        dwait     = 1'b0;
        wait_empty("final_drain");
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
